// File: rtl/tone_seq_pkg.sv
// Shared definitions for the tone step sequencer: FSM states, divisor table and pattern sizing.
package tone_seq_pkg;

  localparam int NUM_STEPS = 8;
  localparam logic [2:0] CODE_SILENT = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Half-period in clocks, indexed by divisor code; entry 0 means silent.
  localparam logic [7:0][6:0] HP_TABLE = {
    7'd34, 7'd38, 7'd43, 7'd48, 7'd51, 7'd57, 7'd64, 7'd0
  };

endpackage

// File: rtl/tone_halfperiod_divider.sv
// Toggle divider: counts to the half-period and flips tone; hp of zero holds the output silent.
module tone_halfperiod_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [6:0] hp,
  output logic       tone
);

  logic [6:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 7'd0;
      tone  <= 1'b0;
    end else if (clear || hp == 7'd0) begin
      count <= 7'd0;
      tone  <= 1'b0;
    end else if (enable) begin
      if (count == hp - 7'd1) begin
        count <= 7'd0;
        tone  <= ~tone;
      end else begin
        count <= count + 7'd1;
      end
    end
  end

endmodule

// File: rtl/tone_step_sequencer.sv
// Plays an 8-entry pattern of divisor codes, holding each step for STEP_CYCLES clocks.
import tone_seq_pkg::*;

module tone_step_sequencer #(
  parameter int STEP_CYCLES = 256
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_code;
  logic       run;
  logic       loop;

  assign clk     = io_in[0];
  assign rst     = io_in[1];
  assign wr_en   = io_in[2];
  assign wr_code = io_in[5:3];
  assign run     = io_in[6];
  assign loop    = io_in[7];

  seq_state_t    state, state_next;
  logic [2:0]    step, step_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    wptr, wptr_next;
  logic [2:0]    pattern [NUM_STEPS];
  logic          pattern_we;
  logic          div_clear;
  logic          div_enable;
  logic [2:0]    code;
  logic          tone;
  logic          busy;

  always_comb begin
    state_next = state;
    step_next  = step;
    timer_next = timer;
    wptr_next  = wptr;
    pattern_we = 1'b0;
    div_clear  = 1'b1;
    div_enable = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          pattern_we = 1'b1;
          wptr_next  = wptr + 3'd1;
        end else if (run) begin
          state_next = PLAY;
          step_next  = 3'd0;
          timer_next = '0;
        end
      end
      PLAY: begin
        if (!run) begin
          state_next = IDLE;
          step_next  = 3'd0;
          timer_next = '0;
        end else if (timer == TIMER_LAST) begin
          // Step boundary: the divider is cleared so the next step starts on a fresh half-period.
          timer_next = '0;
          if (step == LAST_STEP) begin
            if (loop) begin
              step_next = 3'd0;
            end else begin
              state_next = DONE;
            end
          end else begin
            step_next = step + 3'd1;
          end
        end else begin
          timer_next = timer + TW'(1);
          div_clear  = 1'b0;
          div_enable = 1'b1;
        end
      end
      DONE: begin
        if (!run) begin
          state_next = IDLE;
          step_next  = 3'd0;
        end
      end
      default: begin
        state_next = IDLE;
        step_next  = 3'd0;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= 3'd0;
      timer <= '0;
      wptr  <= 3'd0;
    end else begin
      state <= state_next;
      step  <= step_next;
      timer <= timer_next;
      wptr  <= wptr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        pattern[i] <= CODE_SILENT;
      end
    end else if (pattern_we) begin
      pattern[wptr] <= wr_code;
    end
  end

  assign code = pattern[step];
  assign busy = (state == PLAY);

  tone_halfperiod_divider u_divider (
    .clk    (clk),
    .rst    (rst),
    .clear  (div_clear),
    .enable (div_enable),
    .hp     (HP_TABLE[code]),
    .tone   (tone)
  );

  assign io_out = {busy, code, step, tone};

endmodule

// File: tb/tb_tone_step_sequencer.sv
// Randomized bench for tone_step_sequencer against a playback-time model of the pattern player.
module tb_tone_step_sequencer;

  localparam int SC       = 256;
  localparam int PLAY_LEN = 8 * SC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_code = 3'd0;
  logic       run = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {loop, run, wr_code, wr_en, rst, clk};

  tone_step_sequencer #(.STEP_CYCLES(SC)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: playback is tracked as elapsed clocks since PLAY began.
  typedef enum {M_IDLE, M_PLAY, M_DONE} mmode_t;
  mmode_t m_mode;
  int     m_t;
  int     m_wptr;
  int     m_pat[8];
  int     hp_tab[8] = '{0, 64, 57, 51, 48, 43, 38, 34};

  task automatic model_reset();
    m_mode = M_IDLE;
    m_t    = 0;
    m_wptr = 0;
    for (int i = 0; i < 8; i++) m_pat[i] = 0;
  endtask

  task automatic model_clock();
    case (m_mode)
      M_IDLE: begin
        if (wr_en) begin
          m_pat[m_wptr] = int'(wr_code);
          m_wptr = (m_wptr + 1) % 8;
        end else if (run) begin
          m_mode = M_PLAY;
          m_t    = 0;
        end
      end
      M_PLAY: begin
        if (!run) m_mode = M_IDLE;
        else if (m_t == PLAY_LEN - 1) begin
          if (loop) m_t = 0;
          else m_mode = M_DONE;
        end else m_t++;
      end
      default: if (!run) m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [7:0] model_out();
    int s, o, hp;
    logic t;
    case (m_mode)
      M_IDLE: return {1'b0, 3'(m_pat[0]), 3'd0, 1'b0};
      M_DONE: return {1'b0, 3'(m_pat[7]), 3'd7, 1'b0};
      default: begin
        s  = m_t / SC;
        o  = m_t % SC;
        hp = hp_tab[m_pat[s]];
        t  = (hp == 0) ? 1'b0 : 1'((o / hp) % 2);
        return {1'b1, 3'(m_pat[s]), 3'(s), t};
      end
    endcase
  endfunction

  task automatic cycle(input string tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_val(tag, io_out, model_out());
  endtask

  task automatic do_write(input logic [2:0] c, input logic with_run);
    wr_en   = 1'b1;
    wr_code = c;
    run     = with_run;
    cycle("write");
    $display("write code=%0d run=%0d -> io_out=%h", c, with_run, io_out);
    wr_en = 1'b0;
    run   = 1'b0;
  endtask

  // loop_mode: 0/1 fixed, 2 = re-randomized every clock
  task automatic play(input int len, input int loop_mode, input logic wr_noise);
    run = 1'b1;
    for (int i = 0; i < len; i++) begin
      loop    = (loop_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(loop_mode);
      wr_en   = wr_noise && ($urandom_range(0, 15) == 0);
      wr_code = (wr_noise) ? 3'd7 : 3'($urandom_range(0, 7));
      cycle("play");
    end
    wr_en = 1'b0;
    run   = 1'b0;
    cycle("stop");
    cycle("idle");
    $display("play len=%0d loop_mode=%0d noise=%0d -> io_out=%h", len, loop_mode, wr_noise, io_out);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 check_val("reset", io_out, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle("post_reset");

    // Load 1..7,0; the final write also asserts run, which must not start playback.
    for (int i = 0; i < 8; i++) do_write(3'((i + 1) % 8), (i == 7));
    cycle("run_wr_same_cycle");
    play(PLAY_LEN + 60, 0, 1'b1);

    // Looping playback with writes attempted while busy.
    play(2 * PLAY_LEN + 50, 1, 1'b1);

    // Abort at clock 300; next write lands at entry 0.
    play(300, 1, 1'b0);
    do_write(3'd5, 1'b0);
    check_val("wptr_entry0", {5'd0, io_out[6:4]}, 8'd5);

    // Bring wptr back to 0, then a random pattern with a silent step 2.
    for (int i = 0; i < 7; i++) do_write(3'($urandom_range(0, 7)), 1'b0);
    for (int i = 0; i < 8; i++) do_write((i == 2) ? 3'd0 : 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    play(PLAY_LEN + int'($urandom_range(0, 600)), 2, 1'b1);
    play(int'($urandom_range(50, 900)), 2, 1'b0);

    // Asynchronous reset between clock edges in the middle of playback.
    run  = 1'b1;
    loop = 1'b1;
    for (int i = 0; i < 100; i++) cycle("pre_reset");
    @(posedge clk);
    model_clock();
    #2 rst = 1'b1;
    #1 check_val("async_reset", io_out, 8'h00);
    $display("async reset mid-play -> io_out=%h", io_out);
    model_reset();
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle("after_async_reset");
    play(300, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
